// File: rtl/gray_frame_sequencer_pkg.sv
// Shared definitions for the gray frame sequencer: pixel layout, FSM encoding,
// buffer entry format and the RGB332-to-gray conversion.
package gray_frame_sequencer_pkg;

    localparam int PIX_W = 8;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [PIX_W-1:0] gray;
        logic             sof;
        logic             eol;
    } buf_entry_t;

    // Blue carries only 2 bits, so it is doubled to weigh roughly like R and G.
    function automatic logic [PIX_W-1:0] rgb332_to_gray(input logic [PIX_W-1:0] pix);
        logic [4:0] s;
        logic [2:0] a;
        s = {2'b00, pix[R_MSB:R_LSB]} + {2'b00, pix[G_MSB:G_LSB]}
          + {2'b00, pix[B_MSB:B_LSB], 1'b0};
        a = 3'(s / 5'd3);
        return {a, a, a[2:1]};
    endfunction

endpackage

// File: rtl/gray_out_buffer.sv
// Two-entry FIFO holding converted pixels with their frame markers; the head
// entry drives the output stream directly so it stays stable until popped.
module gray_out_buffer
    import gray_frame_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  buf_entry_t i_data,
    input  logic       i_pop,
    input  logic       i_flush,
    output buf_entry_t o_head,
    output logic [1:0] o_count
);

    buf_entry_t r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/gray_frame_sequencer.sv
// Reads one frame of RGB332 pixels in raster order, converts them to gray and
// streams them out on a valid/ready interface with SOF/EOL markers.
module gray_frame_sequencer
    import gray_frame_sequencer_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic [1:0]        dbg_state
);

    localparam int X_W = $clog2(IMG_W);
    localparam int Y_W = $clog2(IMG_H + 1);

    logic [1:0]        r_state;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              r_infl;
    logic              r_infl_sof;
    logic              r_infl_eol;

    buf_entry_t w_head;
    buf_entry_t w_push_data;
    logic [1:0] w_count;
    logic [2:0] w_pending;
    logic       w_pop;
    logic       w_issue;
    logic       w_last;
    logic       w_abort;

    // Stream handshake: a pixel transfers on a cycle where m_valid and m_ready
    // are both high; m_valid only drops after a transfer, on abort or on reset.
    assign m_valid = (w_count != 2'd0);
    assign w_pop   = m_valid & m_ready;
    assign w_abort = abort & ((r_state == ST_RUN) | (r_state == ST_DRAIN));
    assign w_last  = (r_x == X_W'(IMG_W - 1)) & (r_y == Y_W'(IMG_H - 1));

    // A new read lands in the buffer two edges later, so reserve room for it
    // against what is buffered plus the read whose data is arriving now.
    assign w_pending = {1'b0, w_count} + {2'b00, r_infl} - {2'b00, w_pop};
    assign w_issue   = (r_state == ST_RUN) & ~abort & (w_pending < 3'd2);

    always_comb begin
        w_push_data      = '0;
        w_push_data.gray = rgb332_to_gray(rd_data);
        w_push_data.sof  = r_infl_sof;
        w_push_data.eol  = r_infl_eol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_addr     <= ADDR_W'(BASE_ADDR);
            r_infl     <= 1'b0;
            r_infl_sof <= 1'b0;
            r_infl_eol <= 1'b0;
        end else begin
            r_infl <= w_issue;
            if (w_issue) begin
                r_infl_sof <= (r_x == '0) & (r_y == '0);
                r_infl_eol <= (r_x == X_W'(IMG_W - 1));
                r_addr     <= r_addr + ADDR_W'(1);
                if (r_x == X_W'(IMG_W - 1)) begin
                    r_x <= '0;
                    r_y <= r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state <= ST_RUN;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_addr  <= ADDR_W'(BASE_ADDR);
                    end
                end
                ST_RUN: begin
                    if (abort) r_state <= ST_IDLE;
                    else if (w_issue && w_last) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (abort) r_state <= ST_IDLE;
                    else if (w_pop && (w_count == 2'd1) && !r_infl) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    gray_out_buffer u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_infl),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (w_abort),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign busy      = (r_state == ST_RUN) | (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign rd_en     = w_issue;
    assign rd_addr   = r_addr;
    assign m_data    = w_head.gray;
    assign m_sof     = w_head.sof;
    assign m_eol     = w_head.eol;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gray_frame_sequencer.sv
// Self-checking bench for gray_frame_sequencer: a 4x2 frame instance and a
// 2x1 frame instance share clock, reset and a behavioural source RAM.
module tb_gray_frame_sequencer;
    import gray_frame_sequencer_pkg::*;

    localparam int W1 = 4;
    localparam int H1 = 2;
    localparam int N1 = W1 * H1;
    localparam int B1 = 8;
    localparam int W2 = 2;
    localparam int N2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic start = 1'b0, abort = 1'b0, m_ready = 1'b0;
    logic busy, done, rd_en, m_valid, m_sof, m_eol;
    logic [7:0] rd_addr, m_data;
    logic [7:0] rd_data = 8'h00;
    logic [1:0] dbg_state;

    logic start2 = 1'b0, abort2 = 1'b0, m_ready2 = 1'b1;
    logic busy2, done2, rd_en2, m_valid2, m_sof2, m_eol2;
    logic [7:0] rd_addr2, m_data2;
    logic [7:0] rd_data2 = 8'h00;
    logic [1:0] dbg_state2;

    logic [7:0] ram [256];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] rd_addr_q[$];
    int         rd_cyc_q[$];
    logic [9:0] out_q[$];
    int         hs_cyc_q[$];
    int         done_cnt = 0;
    int         done_cyc = 0;
    bit         chk_out = 1'b0;
    bit         hold_pend = 1'b0;
    bit         prev_abort = 1'b0;
    logic [9:0] held;

    logic [7:0] rd2_q[$];
    logic [9:0] out2_q[$];
    int         done2_cnt = 0;

    logic [7:0] conv_in  [6] = '{8'hFF, 8'h00, 8'hE0, 8'h1C, 8'h03, 8'h24};
    logic [7:0] conv_exp [5] = '{8'hDB, 8'h00, 8'h49, 8'h49, 8'h49};

    gray_frame_sequencer #(.IMG_W(W1), .IMG_H(H1), .ADDR_W(8), .BASE_ADDR(B1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_sof(m_sof), .m_eol(m_eol),
        .dbg_state(dbg_state)
    );

    gray_frame_sequencer #(.IMG_W(W2), .IMG_H(1), .ADDR_W(8), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2), .m_valid(m_valid2),
        .m_ready(m_ready2), .m_data(m_data2), .m_sof(m_sof2), .m_eol(m_eol2),
        .dbg_state(dbg_state2)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en)  rd_data  <= ram[rd_addr];
        if (rd_en2) rd_data2 <= ram[rd_addr2];
    end

    // Reference: gray level from the colour-sum rule, markers from raster position.
    function automatic logic [9:0] model_entry(input int idx, input int w, input logic [7:0] pix);
        int r, g, b, a;
        r = int'(pix) / 32;
        g = (int'(pix) / 4) % 8;
        b = int'(pix) % 4;
        a = (r + g + 2 * b) / 3;
        return {8'(a * 32 + a * 4 + a / 2), (idx == 0), ((idx % w) == w - 1)};
    endfunction

    always @(negedge clk) begin
        if (rst_n && hold_pend && !prev_abort) begin
            n_cmp++;
            if ({m_valid, m_data, m_sof, m_eol} !== {1'b1, held}) begin
                n_err++;
                $display("FAIL hold_stable: got %h required %h", {m_valid, m_data, m_sof, m_eol}, {1'b1, held});
            end
        end
        if (chk_out) begin
            n_cmp++;
            if (rd_addr_q.size() - out_q.size() > 2) begin
                n_err++;
                $display("FAIL outstanding: got %0d required <=2", rd_addr_q.size() - out_q.size());
            end
        end
        hold_pend  = rst_n && m_valid && !m_ready;
        held       = {m_data, m_sof, m_eol};
        prev_abort = abort;
        if (rd_en) begin
            rd_addr_q.push_back(rd_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (m_valid && m_ready) begin
            out_q.push_back({m_data, m_sof, m_eol});
            hs_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rd_en2) rd2_q.push_back(rd_addr2);
        if (m_valid2 && m_ready2) out2_q.push_back({m_data2, m_sof2, m_eol2});
        if (done2) done2_cnt++;
    end

    task automatic clear_capture();
        rd_addr_q.delete();
        rd_cyc_q.delete();
        out_q.delete();
        hs_cyc_q.delete();
        done_cnt = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, rd_en, rd_addr, m_valid, m_data, m_sof, m_eol, dbg_state} !==
            {1'b0, 1'b0, 1'b0, 8'(B1), 1'b0, 8'h00, 1'b0, 1'b0, ST_IDLE}) begin
            n_err++;
            $display("FAIL reset_values: got %h required %h",
                     {busy, done, rd_en, rd_addr, m_valid, m_data, m_sof, m_eol, dbg_state},
                     {1'b0, 1'b0, 1'b0, 8'(B1), 1'b0, 8'h00, 1'b0, 1'b0, ST_IDLE});
        end
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, rd_en, m_valid, busy2, m_valid2} !== 5'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b required 00000", {busy, rd_en, m_valid, busy2, m_valid2});
        end
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic test_frame(input string name, input int mode, input bit restart);
        int start_cyc, n;
        logic [9:0] exp_e;
        clear_capture();
        @(posedge clk);
        #1;
        start = 1'b1;
        m_ready = 1'b1;
        start_cyc = cyc;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(posedge clk);
            #1;
            n = cyc - start_cyc;
            start = restart && (n == 4 || n == 11);
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = (n % 4 == 0) || (n % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
        start = 1'b0;
        m_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL %s done_count: got %0d required 1", name, done_cnt);
        end
        n_cmp++;
        if (rd_addr_q.size() != N1) begin
            n_err++;
            $display("FAIL %s read_count: got %0d required %0d", name, rd_addr_q.size(), N1);
        end
        for (int i = 0; i < N1 && i < rd_addr_q.size(); i++) begin
            n_cmp++;
            if (rd_addr_q[i] !== 8'(B1 + i)) begin
                n_err++;
                $display("FAIL %s rd_addr[%0d]: got %0d required %0d", name, i, rd_addr_q[i], B1 + i);
            end
        end
        n_cmp++;
        if (out_q.size() != N1) begin
            n_err++;
            $display("FAIL %s out_count: got %0d required %0d", name, out_q.size(), N1);
        end
        for (int i = 0; i < N1 && i < out_q.size(); i++) begin
            exp_e = model_entry(i, W1, ram[B1 + i]);
            n_cmp++;
            if (out_q[i] !== exp_e) begin
                n_err++;
                $display("FAIL %s out[%0d] {data,sof,eol}: got %h required %h", name, i, out_q[i], exp_e);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL %s end_idle: got busy=%b state=%0d required busy=0 state=0", name, busy, dbg_state);
        end
        if (hs_cyc_q.size() > 0) begin
            n_cmp++;
            if (done_cyc != hs_cyc_q[hs_cyc_q.size() - 1] + 1) begin
                n_err++;
                $display("FAIL %s done_timing: got cycle %0d required %0d", name, done_cyc, hs_cyc_q[hs_cyc_q.size() - 1] + 1);
            end
        end
        if (mode == 0 && rd_cyc_q.size() == N1 && hs_cyc_q.size() == N1) begin
            n_cmp++;
            if (rd_cyc_q[0] != start_cyc + 1 || rd_cyc_q[N1 - 1] != start_cyc + N1) begin
                n_err++;
                $display("FAIL %s read_timing: got %0d..%0d required %0d..%0d", name,
                         rd_cyc_q[0] - start_cyc, rd_cyc_q[N1 - 1] - start_cyc, 1, N1);
            end
            n_cmp++;
            if (hs_cyc_q[0] != start_cyc + 3 || hs_cyc_q[N1 - 1] != start_cyc + N1 + 2) begin
                n_err++;
                $display("FAIL %s out_timing: got %0d..%0d required %0d..%0d", name,
                         hs_cyc_q[0] - start_cyc, hs_cyc_q[N1 - 1] - start_cyc, 3, N1 + 2);
            end
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < N1; i++) ram[B1 + i] = 8'(i);
        test_frame("basic", 0, 1'b0);
    endtask

    task automatic test_conversion();
        logic [9:0] e;
        for (int i = 0; i < 6; i++) ram[B1 + i] = conv_in[i];
        ram[B1 + 6] = 8'($urandom_range(0, 255));
        ram[B1 + 7] = 8'($urandom_range(0, 255));
        test_frame("conversion", 0, 1'b0);
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            e = out_q[i];
            n_cmp++;
            if (e[9:2] !== conv_exp[i]) begin
                n_err++;
                $display("FAIL conv_vector[%0h]: got %h required %h", conv_in[i], e[9:2], conv_exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N1; i++) ram[B1 + i] = 8'($urandom_range(0, 255));
        chk_out = 1'b1;
        test_frame("bp_pattern", 1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N1; i++) ram[B1 + i] = 8'($urandom_range(0, 255));
            test_frame($sformatf("bp_random%0d", k), 2, 1'b0);
        end
        chk_out = 1'b0;
    endtask

    task automatic test_abort();
        int n, snap;
        for (int i = 0; i < N1; i++) ram[B1 + i] = 8'($urandom_range(0, 255));
        clear_capture();
        @(posedge clk);
        #1;
        start = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (out_q.size() < 3 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        snap = out_q.size();
        n_cmp++;
        if ({m_valid, busy, rd_en, dbg_state} !== {1'b0, 1'b0, 1'b0, ST_IDLE}) begin
            n_err++;
            $display("FAIL abort_idle: got valid=%b busy=%b rd_en=%b state=%0d required 0 0 0 0",
                     m_valid, busy, rd_en, dbg_state);
        end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (done_cnt != 0 || out_q.size() != snap) begin
            n_err++;
            $display("FAIL abort_quiet: got done=%0d outs=%0d required done=0 outs=%0d", done_cnt, out_q.size(), snap);
        end
        test_frame("after_abort", 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < N1; i++) ram[B1 + i] = 8'($urandom_range(0, 255));
        test_frame("restart_ignored", 0, 1'b1);
        clear_capture();
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE || rd_addr_q.size() != 0) begin
            n_err++;
            $display("FAIL start_abort_same: got busy=%b state=%0d reads=%0d required 0 0 0",
                     busy, dbg_state, rd_addr_q.size());
        end
    endtask

    task automatic test_reset_drain();
        int n;
        logic [9:0] exp_e;
        for (int i = 0; i < N1; i++) ram[B1 + i] = 8'($urandom_range(1, 255));
        clear_capture();
        @(posedge clk);
        #1;
        start = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (rd_addr_q.size() < N1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dbg_state !== ST_DRAIN || m_valid !== 1'b1) begin
            n_err++;
            $display("FAIL drain_reached: got state=%0d valid=%b required 2 1", dbg_state, m_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, rd_en, rd_addr, m_valid, m_data, m_sof, m_eol, dbg_state} !==
            {1'b0, 1'b0, 1'b0, 8'(B1), 1'b0, 8'h00, 1'b0, 1'b0, ST_IDLE}) begin
            n_err++;
            $display("FAIL async_reset: got %h required %h",
                     {busy, done, rd_en, rd_addr, m_valid, m_data, m_sof, m_eol, dbg_state},
                     {1'b0, 1'b0, 1'b0, 8'(B1), 1'b0, 8'h00, 1'b0, 1'b0, ST_IDLE});
        end
        m_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        n_cmp++;
        if (done_cnt != 0) begin
            n_err++;
            $display("FAIL reset_no_done: got %0d required 0", done_cnt);
        end
        for (int i = 0; i < N2; i++) ram[i] = 8'($urandom_range(0, 255));
        rd2_q.delete();
        out2_q.delete();
        done2_cnt = 0;
        @(posedge clk);
        #1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        n = 0;
        while (done2_cnt == 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done2_cnt != 1 || rd2_q.size() != N2 || out2_q.size() != N2) begin
            n_err++;
            $display("FAIL small_frame_counts: got done=%0d reads=%0d outs=%0d required 1 %0d %0d",
                     done2_cnt, rd2_q.size(), out2_q.size(), N2, N2);
        end
        for (int i = 0; i < N2 && i < rd2_q.size(); i++) begin
            n_cmp++;
            if (rd2_q[i] !== 8'(i)) begin
                n_err++;
                $display("FAIL small_rd_addr[%0d]: got %0d required %0d", i, rd2_q[i], i);
            end
        end
        for (int i = 0; i < N2 && i < out2_q.size(); i++) begin
            exp_e = model_entry(i, W2, ram[i]);
            n_cmp++;
            if (out2_q[i] !== exp_e) begin
                n_err++;
                $display("FAIL small_out[%0d]: got %h required %h", i, out2_q[i], exp_e);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        test_reset();
        test_basic();
        test_conversion();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
